clocks_gen: RTL

Parametrised successor to the simulation clock divider. From one fast master clock it generates single-cycle PPU and CPU clock enables, a CPU phase index, and sequenced PPU/CPU resets. It adds:
- runtime NTSC/PAL divide selection; PPU and CPU dividers are independent, so non-integer ratios (PAL 3.2) work;
- halt/single-step at CPU-cycle granularity for debug;
- automatic reset resequencing on a mode change.

It sits at the top of the NES core and feeds every clock-enabled block.

---
 rtl/clocks_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/clocks_gen.sv
// clocks_gen: master-clock divider for the NES core.
// Produces single-cycle PPU/CPU clock enables, the CPU phase index and
// sequenced PPU/CPU resets from clk_ppu8. NTSC/PAL divide ratios are
// runtime selectable; the PPU and CPU dividers are independent, so
// non-integer ratios (PAL 3.2) come out naturally. Supports halt and
// single-step at CPU-cycle granularity, and resequences resets on a
// mode change.
// Optional feature: define CLOCKS_M2_EN to generate the registered CPU M2
// level; with it undefined m2 is tied low and no logic is built.
module clocks_gen #(
    parameter int unsigned NTSC_PPU_DIV = 8,
    parameter int unsigned NTSC_CPU_DIV = 24,
    parameter int unsigned PAL_PPU_DIV  = 5,
    parameter int unsigned PAL_CPU_DIV  = 16,
    parameter int unsigned RST_PPU_CYC  = 16,
    parameter int unsigned RST_CPU_PPU  = 8,
    parameter int unsigned PW           = 5
) (
    input  logic          clk_ppu8,
    input  logic          rst,
    input  logic          pal,
    input  logic          run,
    input  logic          step,
    output logic          ppu_ce,
    output logic          cpu_ce,
    output logic [PW-1:0] clk_phase,
    output logic          rst_ppu,
    output logic          rst_cpu,
    output logic          halted,
    output logic          m2
);

    // Terminal counts for each mode, pre-truncated to the counter width.
    localparam logic [PW-1:0] NTSC_PPU_LAST = PW'(NTSC_PPU_DIV - 1);
    localparam logic [PW-1:0] NTSC_CPU_LAST = PW'(NTSC_CPU_DIV - 1);
    localparam logic [PW-1:0] PAL_PPU_LAST  = PW'(PAL_PPU_DIV - 1);
    localparam logic [PW-1:0] PAL_CPU_LAST  = PW'(PAL_CPU_DIV - 1);

    // Reset sequencer counter widths: +1 keeps the width >= 1 for tiny values.
    localparam int unsigned RCW = $clog2(RST_PPU_CYC + 1);
    localparam int unsigned PCW = $clog2(RST_CPU_PPU + 1);
    localparam logic [RCW-1:0] RST_PPU_LAST = RCW'(RST_PPU_CYC - 1);
    localparam logic [PCW-1:0] RST_CPU_LAST = PCW'(RST_CPU_PPU - 1);

    logic           mode_q;
    logic [PW-1:0]  ppu_cnt_q, ppu_cnt_d;
    logic [PW-1:0]  cpu_cnt_q, cpu_cnt_d;
    logic           halted_q,  halted_d;
    logic           rst_ppu_q, rst_ppu_d;
    logic           rst_cpu_q, rst_cpu_d;
    logic [RCW-1:0] rcnt_q,    rcnt_d;
    logic [PCW-1:0] pcnt_q,    pcnt_d;

    logic           resync;
    logic [PW-1:0]  ppu_last;
    logic [PW-1:0]  cpu_last;

    // A pal level that disagrees with the latched mode restarts everything,
    // but the external reset takes precedence over it.
    assign resync   = !rst && (pal != mode_q);
    assign ppu_last = mode_q ? PAL_PPU_LAST : NTSC_PPU_LAST;
    assign cpu_last = mode_q ? PAL_CPU_LAST : NTSC_CPU_LAST;

    // Enables are decoded straight from registered state so they land in the
    // first cycle after reset release without an extra pipeline stage.
    assign ppu_ce    = !rst && !resync && !halted_q && (ppu_cnt_q == '0);
    assign cpu_ce    = !rst && !resync && !halted_q && (cpu_cnt_q == '0);
    assign clk_phase = cpu_cnt_q;
    assign rst_ppu   = rst_ppu_q;
    assign rst_cpu   = rst_cpu_q;
    assign halted    = halted_q;

    // Next-state: divider counters, halt/step control and reset sequencing.
    always_comb begin
        ppu_cnt_d = ppu_cnt_q;
        cpu_cnt_d = cpu_cnt_q;
        halted_d  = halted_q;
        rst_ppu_d = rst_ppu_q;
        rst_cpu_d = rst_cpu_q;
        rcnt_d    = rcnt_q;
        pcnt_d    = pcnt_q;

        if (resync) begin
            // Same effect as an external reset, minus the reset input itself.
            ppu_cnt_d = '0;
            cpu_cnt_d = '0;
            halted_d  = 1'b0;
            rst_ppu_d = 1'b1;
            rst_cpu_d = 1'b1;
            rcnt_d    = '0;
            pcnt_d    = '0;
        end else begin
            if (!halted_q) begin
                // Dividers free-run independently; they only realign on reset.
                ppu_cnt_d = (ppu_cnt_q == ppu_last) ? '0 : ppu_cnt_q + PW'(1);
                cpu_cnt_d = (cpu_cnt_q == cpu_last) ? '0 : cpu_cnt_q + PW'(1);
                // Halt only at the CPU-cycle boundary; cpu_cnt wraps to 0 so
                // the resume cycle carries cpu_ce. A pending step re-halts
                // here too, which is what bounds a step to one CPU cycle.
                if (!run && (cpu_cnt_q == cpu_last)) begin
                    halted_d = 1'b1;
                end
            end else if (run || step) begin
                // run and step both release the halt; with run high the
                // boundary check above never re-halts, so run wins.
                halted_d = 1'b0;
            end

            // rst_ppu: fixed master-cycle count after release.
            if (rst_ppu_q) begin
                if (rcnt_q == RST_PPU_LAST) begin
                    rst_ppu_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end else if (rst_cpu_q && ppu_ce) begin
                // rst_cpu: counts PPU enables, so it stalls while halted.
                if (pcnt_q == RST_CPU_LAST) begin
                    rst_cpu_d = 1'b0;
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                end
            end
        end
    end

    // State registers with synchronous reset; mode follows pal every cycle
    // (it only differs from pal during the resync cycle).
    always_ff @(posedge clk_ppu8) begin
        mode_q <= pal;
        if (rst) begin
            ppu_cnt_q <= '0;
            cpu_cnt_q <= '0;
            halted_q  <= 1'b0;
            rst_ppu_q <= 1'b1;
            rst_cpu_q <= 1'b1;
            rcnt_q    <= '0;
            pcnt_q    <= '0;
        end else begin
            ppu_cnt_q <= ppu_cnt_d;
            cpu_cnt_q <= cpu_cnt_d;
            halted_q  <= halted_d;
            rst_ppu_q <= rst_ppu_d;
            rst_cpu_q <= rst_cpu_d;
            rcnt_q    <= rcnt_d;
            pcnt_q    <= pcnt_d;
        end
    end

`ifdef CLOCKS_M2_EN
    // M2 rises 3/8 of the way through the CPU cycle.
    localparam logic [PW-1:0] NTSC_M2_TH = PW'((NTSC_CPU_DIV * 3) / 8);
    localparam logic [PW-1:0] PAL_M2_TH  = PW'((PAL_CPU_DIV * 3) / 8);

    logic          m2_q, m2_d;
    logic [PW-1:0] m2_th;

    assign m2_th = mode_q ? PAL_M2_TH : NTSC_M2_TH;

    // M2 level from the current phase; held low while halted or resyncing.
    always_comb begin
        m2_d = !resync && !halted_q && (cpu_cnt_q >= m2_th);
    end

    // Registered for a glitch-free level; lags cpu_cnt by one cycle.
    always_ff @(posedge clk_ppu8) begin
        if (rst) begin
            m2_q <= 1'b0;
        end else begin
            m2_q <= m2_d;
        end
    end

    assign m2 = m2_q;
`else
    assign m2 = 1'b0;
`endif

endmodule
